// File: rtl/pulse_height_analyzer_pkg.sv
// Shared MCA types: default widths, FSM state encoding, channel type.
// Imported by the pulse-height analyzer and its neighbours.
package mca_pkg;

   localparam int ADC_W = 14;
   localparam int CH_W  = 10;

   typedef logic [CH_W-1:0] channel_t;

   typedef enum logic [2:0] {
      REARM,
      IDLE,
      TRACK,
      EMIT,
      DEAD
   } state_e;

endpackage

// File: rtl/pulse_height_analyzer_if.sv
// Channel-index valid/ready link from the analyzer to the histogram.
// master drives valid/channel, slave answers with ready.
interface pulse_height_analyzer_if;
   import mca_pkg::*;

   logic     ch_valid;
   logic     ch_ready;
   channel_t channel;

   modport master (
      output ch_valid,
      output channel,
      input  ch_ready
   );

   modport slave (
      input  ch_valid,
      input  channel,
      output ch_ready
   );

endinterface

// File: rtl/pulse_height_analyzer_sat_counter.sv
// Saturating event counter: holds at all-ones, never wraps.
// Cleared by synchronous active-high reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // next count: step on inc unless already full
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pulse_height_analyzer.sv
// Pulse-height analyzer: threshold trigger, peak capture, pile-up
// rejection and dead time, emitting one channel index per pulse.
module pulse_height_analyzer #(
   parameter int ADC_W    = mca_pkg::ADC_W,
   parameter int CH_W     = mca_pkg::CH_W,
   parameter int DEAD_CYC = 8,
   parameter int MAX_LEN  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_valid_i,
   input  logic [ADC_W-1:0]        sample_i,
   input  logic [ADC_W-1:0]        threshold_i,
   pulse_height_analyzer_if.master ch_if,
   output logic [31:0]             pulse_cnt_o,
   output logic [15:0]             reject_cnt_o,
   output logic                    busy_o
);
   import mca_pkg::*;

   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int DCNT_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
   localparam int D_LAST = (DEAD_CYC > 1) ? DEAD_CYC - 1 : 0;

   state_e            state_q;
   logic [ADC_W-1:0]  peak_q;
   logic [ADC_W-1:0]  thr_q;
   logic [LEN_W-1:0]  len_q;
   logic              ovl_q;
   logic [DCNT_W-1:0] dcnt_q;
   logic              ch_valid_q;
   logic [CH_W-1:0]   channel_q;
   logic              busy_q;

   logic above_live;
   logic above_lat;
   logic pulse_inc;
   logic reject_inc;

   assign above_live = sample_i > threshold_i;
   assign above_lat  = sample_i > thr_q;
   assign pulse_inc  = ch_valid_q & ch_if.ch_ready;
   assign reject_inc = (state_q == TRACK) & sample_valid_i
                     & ~above_lat & ovl_q;

   // pulse FSM: rearm, trigger, track peak, emit or reject, dead time
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= REARM;
         peak_q     <= '0;
         thr_q      <= '0;
         len_q      <= '0;
         ovl_q      <= 1'b0;
         dcnt_q     <= '0;
         ch_valid_q <= 1'b0;
         channel_q  <= '0;
         busy_q     <= 1'b1;
      end else begin
         unique case (state_q)
            REARM: begin
               if (sample_valid_i && !above_live) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            IDLE: begin
               if (sample_valid_i && above_live) begin
                  state_q <= TRACK;
                  busy_q  <= 1'b1;
                  peak_q  <= sample_i;
                  len_q   <= LEN_W'(1);
                  thr_q   <= threshold_i;
                  ovl_q   <= 1'b0;
               end
            end
            TRACK: begin
               if (sample_valid_i) begin
                  if (above_lat) begin
                     if (sample_i > peak_q) begin
                        peak_q <= sample_i;
                     end
                     if (len_q == LEN_W'(MAX_LEN)) begin
                        ovl_q <= 1'b1;
                     end else begin
                        len_q <= len_q + 1'b1;
                     end
                  end else if (ovl_q) begin
                     state_q <= DEAD;
                     dcnt_q  <= '0;
                  end else begin
                     state_q    <= EMIT;
                     ch_valid_q <= 1'b1;
                     channel_q  <= peak_q[ADC_W-1 -: CH_W];
                  end
               end
            end
            EMIT: begin
               if (ch_if.ch_ready) begin
                  state_q    <= DEAD;
                  ch_valid_q <= 1'b0;
                  dcnt_q     <= '0;
               end
            end
            DEAD: begin
               if (dcnt_q == DCNT_W'(D_LAST)) begin
                  state_q <= REARM;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= REARM;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   sat_counter #(.W(32)) u_pulse_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (pulse_inc),
      .count_o (pulse_cnt_o)
   );

   sat_counter #(.W(16)) u_reject_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (reject_inc),
      .count_o (reject_cnt_o)
   );

   assign ch_if.ch_valid = ch_valid_q;
   assign ch_if.channel  = channel_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_pulse_height_analyzer.sv
// Bench for pulse_height_analyzer: directed scenarios plus random
// streams checked against a pulse-level reference model.
module tb_pulse_height_analyzer;

   localparam int ADC_W    = 14;
   localparam int CH_W     = 10;
   localparam int DEAD_CYC = 8;
   localparam int MAX_LEN  = 64;
   localparam longint PMAX = 64'hFFFF_FFFF;
   localparam longint RMAX = 64'hFFFF;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_valid;
   logic [ADC_W-1:0]  sample;
   logic [ADC_W-1:0]  threshold;
   logic [31:0]       pulse_cnt;
   logic [15:0]       reject_cnt;
   logic              busy;

   pulse_height_analyzer_if ch_if ();

   always #5 clk = ~clk;

   pulse_height_analyzer #(
      .ADC_W    (ADC_W),
      .CH_W     (CH_W),
      .DEAD_CYC (DEAD_CYC),
      .MAX_LEN  (MAX_LEN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sample_valid_i (sample_valid),
      .sample_i       (sample),
      .threshold_i    (threshold),
      .ch_if          (ch_if),
      .pulse_cnt_o    (pulse_cnt),
      .reject_cnt_o   (reject_cnt),
      .busy_o         (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // pulse-level model: waiting for a below sample, inside a pulse,
   // holding an output, or ignoring samples until cycle m_resume
   bit     m_wait, m_in, m_out;
   int     m_peak, m_len, m_thr, m_ch, m_resume;
   longint m_pcnt, m_rcnt;

   function automatic void model_edge(bit r, bit v, int s, int thr,
                                      bit rdy);
      int dead;
      dead = (DEAD_CYC > 0) ? DEAD_CYC : 1;
      if (r) begin
         m_wait = 1; m_in = 0; m_out = 0; m_ch = 0;
         m_pcnt = 0; m_rcnt = 0; m_resume = 0;
         return;
      end
      if (m_out) begin
         if (rdy) begin
            m_out = 0;
            if (m_pcnt < PMAX) m_pcnt++;
            m_resume = cyc + dead + 1;
         end
         return;
      end
      if (cyc < m_resume || !v) return;
      if (m_wait) begin
         if (s <= thr) m_wait = 0;
      end else if (!m_in) begin
         if (s > thr) begin
            m_in = 1; m_peak = s; m_len = 1; m_thr = thr;
         end
      end else if (s > m_thr) begin
         if (s > m_peak) m_peak = s;
         m_len++;
      end else begin
         m_in = 0;
         m_wait = 1;
         if (m_len > MAX_LEN) begin
            if (m_rcnt < RMAX) m_rcnt++;
            m_resume = cyc + dead + 1;
         end else begin
            m_out = 1;
            m_ch = m_peak / (1 << (ADC_W - CH_W));
         end
      end
   endfunction

   // one clock: drive at negedge, edge, model, back to negedge
   task automatic step(bit v, int s, int thr = 200, bit rdy = 1,
                       bit r = 0);
      rst = r;
      sample_valid = v;
      sample = ADC_W'(s);
      threshold = ADC_W'(thr);
      ch_if.ch_ready = rdy;
      @(posedge clk);
      model_edge(r, v, s, thr, rdy);
      cyc++;
      @(negedge clk);
   endtask

   task automatic quiet(int n);
      for (int i = 0; i < n; i++) step(1, 0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 200, 1, 1);
      n_cmp += 5;
      if (ch_if.ch_valid !== 1'b0) begin n_bad++;
         $display("FAIL reset_valid got %b exp 0", ch_if.ch_valid); end
      if (ch_if.channel !== 10'd0) begin n_bad++;
         $display("FAIL reset_chan got %0d exp 0", ch_if.channel); end
      if (pulse_cnt !== 32'd0) begin n_bad++;
         $display("FAIL reset_pcnt got %0d exp 0", pulse_cnt); end
      if (reject_cnt !== 16'd0) begin n_bad++;
         $display("FAIL reset_rcnt got %0d exp 0", reject_cnt); end
      if (busy !== 1'b1) begin n_bad++;
         $display("FAIL reset_busy got %b exp 1", busy); end
   endtask

   task automatic test_basic();
      int hi;
      step(1, 50);
      step(1, 100); step(1, 5000); step(1, 9000); step(1, 7000);
      step(1, 50);
      n_cmp += 2;
      if (ch_if.ch_valid !== 1'b1) begin n_bad++;
         $display("FAIL basic_valid got %b exp 1", ch_if.ch_valid); end
      if (ch_if.channel !== 10'd562) begin n_bad++;
         $display("FAIL basic_chan got %0d exp 562", ch_if.channel); end
      hi = 1;
      for (int i = 0; i < 12; i++) begin
         step(1, 50);
         if (ch_if.ch_valid === 1'b1) hi++;
      end
      n_cmp += 2;
      if (hi != 1) begin n_bad++;
         $display("FAIL basic_once got %0d exp 1", hi); end
      if (pulse_cnt !== 32'(m_pcnt) || m_pcnt != 1) begin n_bad++;
         $display("FAIL basic_pcnt got %0d exp 1", pulse_cnt); end
   endtask

   task automatic test_backpressure();
      int hi;
      step(1, 100); step(1, 5000); step(1, 9000); step(1, 7000);
      step(1, 50, 200, 0);
      hi = (ch_if.ch_valid === 1'b1) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 10000, 200, 0);
         if (ch_if.ch_valid === 1'b1) hi++;
         n_cmp += 2;
         if (ch_if.channel !== 10'd562) begin n_bad++;
            $display("FAIL bp_chan got %0d exp 562", ch_if.channel); end
         if (pulse_cnt !== 32'd1) begin n_bad++;
            $display("FAIL bp_pcnt_hold got %0d exp 1", pulse_cnt); end
      end
      step(1, 10000, 200, 1);
      n_cmp += 3;
      if (hi != 6) begin n_bad++;
         $display("FAIL bp_hold got %0d exp 6", hi); end
      if (ch_if.ch_valid !== 1'b0) begin n_bad++;
         $display("FAIL bp_drop got %b exp 0", ch_if.ch_valid); end
      if (pulse_cnt !== 32'd2) begin n_bad++;
         $display("FAIL bp_pcnt got %0d exp 2", pulse_cnt); end
      quiet(14);
   endtask

   task automatic test_max_len();
      for (int i = 0; i < MAX_LEN; i++) step(1, 3000);
      step(1, 0);
      n_cmp += 2;
      if (ch_if.ch_valid !== 1'b1) begin n_bad++;
         $display("FAIL len64_valid got %b exp 1", ch_if.ch_valid); end
      if (ch_if.channel !== 10'd187) begin n_bad++;
         $display("FAIL len64_chan got %0d exp 187", ch_if.channel); end
      quiet(12);
      for (int i = 0; i < MAX_LEN + 1; i++) step(1, 3000);
      step(1, 0);
      n_cmp += 3;
      if (ch_if.ch_valid !== 1'b0) begin n_bad++;
         $display("FAIL len65_valid got %b exp 0", ch_if.ch_valid); end
      if (reject_cnt !== 16'd1) begin n_bad++;
         $display("FAIL len65_rcnt got %0d exp 1", reject_cnt); end
      if (pulse_cnt !== 32'd3) begin n_bad++;
         $display("FAIL len65_pcnt got %0d exp 3", pulse_cnt); end
      quiet(12);
   endtask

   task automatic test_dead_time();
      int hi = 0;
      step(1, 9000); step(1, 50);
      step(1, 50);
      step(1, 50); step(1, 50);
      for (int i = 0; i < 10; i++) begin
         step(1, 4000);
         if (ch_if.ch_valid === 1'b1) hi++;
      end
      step(1, 50);
      if (ch_if.ch_valid === 1'b1) hi++;
      n_cmp += 2;
      if (hi != 0) begin n_bad++;
         $display("FAIL dead_ignored got %0d exp 0", hi); end
      if (busy !== 1'b0) begin n_bad++;
         $display("FAIL dead_rearmed got %b exp 0", busy); end
      step(1, 4000); step(1, 4000); step(1, 4000); step(1, 50);
      n_cmp += 2;
      if (ch_if.ch_valid !== 1'b1) begin n_bad++;
         $display("FAIL dead_next_valid got %b exp 1", ch_if.ch_valid); end
      if (ch_if.channel !== 10'd250) begin n_bad++;
         $display("FAIL dead_next_chan got %0d exp 250", ch_if.channel); end
      quiet(12);
   endtask

   task automatic test_reset_mid();
      step(1, 5000); step(1, 9000);
      step(1, 9000, 200, 1, 1);
      n_cmp += 4;
      if (ch_if.ch_valid !== 1'b0) begin n_bad++;
         $display("FAIL rmid_valid got %b exp 0", ch_if.ch_valid); end
      if (pulse_cnt !== 32'd0) begin n_bad++;
         $display("FAIL rmid_pcnt got %0d exp 0", pulse_cnt); end
      if (reject_cnt !== 16'd0) begin n_bad++;
         $display("FAIL rmid_rcnt got %0d exp 0", reject_cnt); end
      if (busy !== 1'b1) begin n_bad++;
         $display("FAIL rmid_busy got %b exp 1", busy); end
      for (int i = 0; i < 5; i++) begin
         step(1, 9000 + i);
         n_cmp++;
         if (busy !== 1'b1 || ch_if.ch_valid !== 1'b0) begin n_bad++;
            $display("FAIL rmid_notrig busy %b exp 1", busy); end
      end
      step(1, 50);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++;
         $display("FAIL rmid_idle got %b exp 0", busy); end
   endtask

   task automatic test_full_scale();
      for (int i = 0; i < 40; i++) begin
         step(1, 16383);
         step(0, 0);
      end
      step(1, 0);
      n_cmp += 2;
      if (ch_if.ch_valid !== 1'b1) begin n_bad++;
         $display("FAIL fs_valid got %b exp 1", ch_if.ch_valid); end
      if (ch_if.channel !== 10'd1023) begin n_bad++;
         $display("FAIL fs_chan got %0d exp 1023", ch_if.channel); end
      quiet(12);
   endtask

   task automatic test_random();
      int thr = 6000;
      int seg = 0;
      bit up = 0;
      int s;
      bit v, rdy;
      for (int i = 0; i < 3000; i++) begin
         if (seg == 0) begin
            seg = $urandom_range(1, 90);
            up = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) thr = $urandom_range(1000, 12000);
         end
         seg--;
         if (up) s = $urandom_range(thr + 1, 16383);
         else s = $urandom_range(0, thr);
         if ($urandom_range(0, 30) == 0) s = thr;
         v = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 9) < 7);
         step(v, s, thr, rdy);
         n_cmp += 4;
         if (ch_if.ch_valid !== m_out) begin n_bad++;
            $display("FAIL rand_valid cyc %0d got %b exp %b",
                     cyc, ch_if.ch_valid, m_out); end
         if (m_out && ch_if.channel !== 10'(m_ch)) begin n_bad++;
            $display("FAIL rand_chan cyc %0d got %0d exp %0d",
                     cyc, ch_if.channel, m_ch); end
         if (pulse_cnt !== 32'(m_pcnt) || reject_cnt !== 16'(m_rcnt))
         begin n_bad++;
            $display("FAIL rand_cnt cyc %0d got %0d/%0d exp %0d/%0d",
                     cyc, pulse_cnt, reject_cnt, m_pcnt, m_rcnt); end
         if (busy !== (m_wait | m_in | m_out)) begin n_bad++;
            $display("FAIL rand_busy cyc %0d got %b exp %b",
                     cyc, busy, m_wait | m_in | m_out); end
      end
      quiet(30);
   endtask

   task automatic test_saturation();
      force dut.u_pulse_cnt.count_q = 32'hFFFF_FFFE;
      m_pcnt = 64'hFFFF_FFFE;
      step(1, 0);
      release dut.u_pulse_cnt.count_q;
      for (int p = 0; p < 3; p++) begin
         step(1, 5000); step(1, 6000); step(1, 0);
         step(1, 0);
         n_cmp++;
         if (pulse_cnt !== 32'(m_pcnt)) begin n_bad++;
            $display("FAIL sat_step%0d got %h exp %h", p, pulse_cnt,
                     32'(m_pcnt)); end
         quiet(12);
      end
      n_cmp++;
      if (pulse_cnt !== 32'hFFFF_FFFF) begin n_bad++;
         $display("FAIL sat_hold got %h exp ffffffff", pulse_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      sample_valid = 1'b0;
      sample = '0;
      threshold = '0;
      ch_if.ch_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_max_len();
      test_dead_time();
      test_reset_mid();
      test_full_scale();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_height_analyzer.md
Name: pulse_height_analyzer

Overview:
- Upstream feeder for the MCA histogram stage.
- Consumes a streamed unsigned ADC sample train and detects pulses crossing a programmable threshold.
- Captures each pulse's maximum and emits it as a channel index over a valid/ready handshake.
- Downstream, the histogram accumulator adds one count to `count[channel]` per accepted handshake.
- Also applies dead-time, over-length (pile-up) rejection and statistics counters.

Parameters:
- ADC_W, 14, sample width in bits (unsigned).
- CH_W, 10, channel index width; channel = peak[ADC_W-1 -: CH_W] (1024 channels).
- DEAD_CYC, 8, clock cycles of dead time after each emitted or rejected pulse; 0 is legal.
- MAX_LEN, 64, maximum accepted pulse length in valid samples above threshold.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sample_valid  in  1  sample qualifier; samples with sample_valid=0 are ignored entirely.
- sample  in  ADC_W  ADC sample, unsigned.
- threshold  in  ADC_W  trigger level; latched at pulse start.
- ch_valid  out  1  channel output valid.
- ch_ready  in  1  downstream accept.
- channel  out  CH_W  pulse-height channel index.
- pulse_cnt  out  32  accepted (handshaken) pulses, saturating.
- reject_cnt  out  16  over-length pulses rejected, saturating.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: ch_valid=0, channel=0, pulse_cnt=0, reject_cnt=0, busy=1, state=REARM.
- Reset mid-pulse, mid-EMIT or mid-DEAD discards everything in progress, with no count and no output.
- "Above" means sample > threshold_latched, strictly; a sample equal to the threshold counts as below.
- State REARM: on a valid sample <= threshold (live threshold), go to IDLE. This guarantees no partial pulse is ever measured.
- State IDLE: on a valid sample > threshold, go to TRACK with:
  - peak <= sample
  - len <= 1
  - thr_l <= threshold
  - ovl <= 0
- State TRACK, on each valid sample:
  - if above: peak <= max(peak, sample); len <= len+1, saturating at MAX_LEN; ovl <= 1 once len has reached MAX_LEN and a further above sample arrives.
  - if below and ovl=0: go to EMIT.
  - if below and ovl=1: reject_cnt++ and go to DEAD.
  - The falling sample is never compared into peak.
- State EMIT:
  - ch_valid=1; channel = peak[ADC_W-1 -: CH_W], registered and stable while ch_valid=1.
  - Samples are ignored.
  - On ch_valid && ch_ready: pulse_cnt++, ch_valid <= 0, go to DEAD.
  - Backpressure is unbounded; there is no timeout.
- State DEAD:
  - Counts DEAD_CYC clock cycles (not samples), ignoring samples, then goes to REARM.
  - With DEAD_CYC=0, go directly to REARM on the next cycle.
- Latency: the falling sample is accepted at the cycle-n edge; ch_valid=1 from cycle n+1.
  - With ch_ready held high, the handshake completes in cycle n+1.
  - The earliest next trigger is after DEAD plus a below-threshold sample.
- Width rules:
  - len counter is clog2(MAX_LEN+1) bits.
  - Dead counter is clog2(DEAD_CYC+1) bits, minimum 1.
  - Full-scale sample 2^ADC_W-1 maps to channel 2^CH_W-1.
  - Counters hold at all-ones and never wrap.
- Exactly MAX_LEN above samples is accepted; MAX_LEN+1 is rejected.
- threshold changes during TRACK have no effect on the current pulse.

Decomposition:
- Package mca_pkg holds:
  - ADC_W, CH_W defaults
  - the state enum {REARM, IDLE, TRACK, EMIT, DEAD}
  - a typedef for channel_t (logic [CH_W-1:0]), shared with the histogram and peak-finder stages
- One sub-module is natural: sat_counter (parameterised width, inc, rst, count). It is instantiated for pulse_cnt and reject_cnt.

Test Plan:
- threshold=200, after one sample of 50, samples 100, 5000, 9000, 7000, 50, ch_ready=1 -> one ch_valid cycle with channel=562 (9000>>4), 1 cycle after the 50 sample is accepted; pulse_cnt=1.
- Same pulse with ch_ready=0 for 5 cycles -> ch_valid held 6 cycles, channel stable at 562, trailing samples ignored; pulse_cnt increments only at the handshake.
- 64 samples of 3000 then 0 -> channel=187 accepted. 65 samples of 3000 then 0 -> no ch_valid, reject_cnt=1, pulse_cnt unchanged.
- DEAD_CYC=8: second pulse (4000) starts 3 cycles after the handshake and lasts 10 samples -> ignored. No re-trigger until a below-threshold sample after DEAD; the next clean pulse of 4000 -> channel=250.
- Reset asserted during TRACK at peak 9000 -> no output, counters 0, state REARM. A reset issued while the input is above threshold -> no trigger until a sample <= threshold is seen.
- Full-scale sample 16383 with sample_valid toggling every other cycle -> channel=1023. Cycles with sample_valid=0 do not advance len. Force pulse_cnt to 2^32-2, then 3 pulses -> pulse_cnt holds at 2^32-1.
